neighbor_fifo_dispatch: RTL
===========================

NEIGHBOR_FIFO_DISPATCH -- requirements
Module: neighbor_fifo_dispatch

Interface
REQ-001 Parameter DEPTH, default 8: entry count of the neighbor FIFO; power of two, at least 4.
REQ-002 Parameter ADDR_W, default `Neighbor_info_bandwidth: width of the neighbor address word.
REQ-003 Parameter NUM_PE, default `Num_Edge_PE: number of edge PE destinations.
REQ-004 Port clk, input, 1: the single clock.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port wr_valid, input, 1: write strobe from the neighbor-info controller output register.
REQ-007 Port wr_addr, input, ADDR_W: neighbor address word.
REQ-008 Port wr_pe_tag, input, $clog2(NUM_PE): destination PE.
REQ-009 Port full, output, 1: back-pressure to the neighbor-info controller.
REQ-010 Port empty, output, 1: no entry is stored and none is held.
REQ-011 Port pe_valid, output, NUM_PE: one-hot offer to the destination PE.
REQ-012 Port pe_addr, output, ADDR_W: offered address, shared by all PEs.
REQ-013 Port pe_ready, input, NUM_PE: per-PE accept.
REQ-014 Port ovf_err, output, 1: sticky overflow flag, present only with the feature in REQ-030.

Function
REQ-015 Storage: circular buffer of DEPTH entries {addr, pe_tag}, with wptr, rptr and count; count is $clog2(DEPTH)+1 bits wide.
REQ-016 A write occurs every cycle wr_valid=1 and count<DEPTH; wr_valid is never qualified by full, because the writer self-throttles.
REQ-017 full=1 when count>=DEPTH-2; the two reserved slots cover the writer's 2-cycle pop-to-data latency. full is combinational from count.
REQ-018 Pointers wrap modulo DEPTH with no skipped entry.
REQ-019 Dispatch FSM, state IDLE: when count>0, pop the head into the hold register and go to OFFER next cycle.
REQ-020 Dispatch FSM, state OFFER: pe_valid[hold_tag]=1 and every other bit is 0; pe_addr=hold_addr.
REQ-021 In OFFER, on pe_ready[hold_tag]=1: the transfer completes. If count>0, pop the next head the same cycle and stay in OFFER; otherwise go to IDLE.
REQ-022 pe_ready bits other than hold_tag are ignored. pe_valid and pe_addr are held stable until the transfer completes.
REQ-023 A write and a pop in the same cycle leave count unchanged; a write into an empty FIFO is poppable the next cycle.
REQ-024 Minimum latency is 2 cycles from a wr_valid edge to pe_valid: 1 cycle to store, 1 cycle to pop into hold. With pe_ready held at 1, throughput is 1 entry per cycle.
REQ-025 empty=1 iff count==0 and the state is IDLE.
REQ-026 pe_valid, pe_addr and the hold register are driven from flops only; there is no combinational path from wr_* to pe_*.

Reset
REQ-027 Asserting reset at any time, including mid-offer, immediately sets wptr=rptr=count=0 and state=IDLE, and clears the hold register. Stored entries are discarded.
REQ-028 Output values during reset: pe_valid=0, pe_addr=0, full=0, empty=1, ovf_err=0.
REQ-029 The first write is accepted on the first rising clk edge after reset deasserts.

Configuration
REQ-030 Macro NBR_FIFO_OVF_CHECK_EN, when defined: ovf_err is set on wr_valid=1 with count==DEPTH, the write is dropped, and ovf_err stays 1 until reset.
REQ-031 When NBR_FIFO_OVF_CHECK_EN is undefined: the ovf_err port and its logic are absent, and a write with count==DEPTH is silently dropped.

Verification
REQ-032 Single write, DEPTH=8: reset, write addr=0x1A, tag=2, pe_ready=0 -> two cycles later pe_valid=4'b0100 and pe_addr=0x1A, held 5 cycles; then pe_ready[2]=1 -> pe_valid=0 the next cycle, empty=1.
REQ-033 Fill with all pe_ready=0: write 7 entries back-to-back -> one entry moves to hold; full=1 once count reaches 6; count never exceeds 8; all 7 entries are later delivered in order.
REQ-034 Streaming with all pe_ready=1: write 20 entries with tags cycling 0..3 -> 20 transfers in order, at 1 per cycle after 2 cycles of latency, and full is never asserted.
REQ-035 Wrong-PE ready: hold entry with tag=1, drive pe_ready=4'b1101 -> no transfer; then pe_ready=4'b0010 -> transfer.
REQ-036 Reset mid-operation: with 4 entries stored and one offered, assert reset asynchronously -> pe_valid=0 and empty=1 before the next clk edge; no stale entry appears after reset.
REQ-037 Overflow, with the macro defined: with count==8, write addr=0x55 -> ovf_err=1 and sticky; 0x55 is never delivered.

Source files
------------

// File: rtl/neighbor_fifo_dispatch.sv
// Neighbor-address FIFO feeding a one-hot edge-PE dispatcher through a single hold register.
// Optional build macro NBR_FIFO_OVF_CHECK_EN adds the sticky ovf_err output.
`ifndef Neighbor_info_bandwidth
`define Neighbor_info_bandwidth 8
`endif
`ifndef Num_Edge_PE
`define Num_Edge_PE 4
`endif

// state | meaning
// IDLE  | hold register empty; pops the FIFO head as soon as count > 0
// OFFER | hold register valid; pe_valid[hold_tag] asserted until that PE accepts
module neighbor_fifo_dispatch #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = `Neighbor_info_bandwidth,
    parameter int NUM_PE = `Num_Edge_PE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_valid,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [$clog2(NUM_PE)-1:0] wr_pe_tag,
    output logic                      full,
    output logic                      empty,
    output logic [NUM_PE-1:0]         pe_valid,
    output logic [ADDR_W-1:0]         pe_addr,
    input  logic [NUM_PE-1:0]         pe_ready
`ifdef NBR_FIFO_OVF_CHECK_EN
    ,
    output logic                      ovf_err
`endif
);

    localparam int TAG_W = $clog2(NUM_PE);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  CNT_DEPTH = CNT_W'(DEPTH);
    // Two slots reserved for the writer's pop-to-data latency.
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH - 2);
    localparam logic [NUM_PE-1:0] PE_ONE    = NUM_PE'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [TAG_W-1:0]  mem_tag  [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] hold_addr;
    logic [TAG_W-1:0]  hold_tag;
    logic [NUM_PE-1:0] hold_valid;
    logic              wr_en;
    logic              pop;
    logic              xfer_done;

    assign wr_en    = wr_valid && (count < CNT_DEPTH);
    assign full     = (count >= CNT_FULL);
    assign empty    = (count == '0) && (state == IDLE);
    assign pe_valid = hold_valid;
    assign pe_addr  = hold_addr;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        xfer_done  = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = OFFER;
                end
            end
            OFFER: begin
                if (pe_ready[hold_tag]) begin
                    xfer_done = 1'b1;
                    if (count != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            hold_addr  <= '0;
            hold_tag   <= '0;
            hold_valid <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count + CNT_W'(wr_en) - CNT_W'(pop);
            // One-hot offer is registered with the entry so pe_* come straight from flops.
            if (pop) begin
                hold_addr  <= mem_addr[rptr];
                hold_tag   <= mem_tag[rptr];
                hold_valid <= PE_ONE << mem_tag[rptr];
            end else if (xfer_done) begin
                hold_valid <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_addr[wptr] <= wr_addr;
            mem_tag[wptr]  <= wr_pe_tag;
        end
    end

`ifdef NBR_FIFO_OVF_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_err <= 1'b0;
        end else if (wr_valid && (count == CNT_DEPTH)) begin
            ovf_err <= 1'b1;
        end
    end
`endif

endmodule
